hazard_fwd_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the SimpleRisc in-order pipeline. It keeps a shadow scoreboard of every in-flight instruction downstream of Operand Fetch (OF): valid flag, destination register, write-back flag and load flag. Each cycle it produces the OF data-interlock, the per-operand forwarding selects and the branch flush. It replaces the fixed EX/MA/RW hazard logic and supports any pipeline depth and any load-result stage.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/fwd_match.sv | 32 +++
 rtl/hazard_fwd_ctrl.sv | 104 ++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and default constants for the SimpleRisc hazard/forwarding controller.
package hazard_pkg;

    localparam int REG_IDX_W_DEF  = 4;
    localparam int NUM_STAGES_DEF = 3;
    localparam int LOAD_STAGE_DEF = 2;
    localparam int REG_IDX_W_MAX  = 8;
    localparam int SEL_RF         = 0;

    // rd is stored at the widest supported index width; narrower indices are zero-extended.
    typedef struct packed {
        logic                     v;
        logic [REG_IDX_W_MAX-1:0] rd;
        logic                     wb;
        logic                     ld;
    } sb_entry_t;

endpackage

// File: rtl/fwd_match.sv
// Combinational priority matcher: finds the youngest scoreboard stage writing a given source.
module fwd_match #(
    parameter int IDX_W      = 8,
    parameter int NUM_STAGES = 3,
    parameter int SEL_W      = 2
) (
    input  logic                        en,
    input  logic [IDX_W-1:0]            src,
    input  logic [NUM_STAGES-1:0]       v,
    input  logic [NUM_STAGES-1:0]       wb,
    input  logic [NUM_STAGES-1:0]       ld,
    input  logic [NUM_STAGES*IDX_W-1:0] rd,
    output logic                        hit,
    output logic [SEL_W-1:0]            idx,
    output logic                        hit_ld
);

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        hit    = 1'b0;
        idx    = '0;
        hit_ld = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (en && v[i] && wb[i] && (rd[i*IDX_W +: IDX_W] == src)) begin
                hit    = 1'b1;
                idx    = SEL_W'(i);
                hit_ld = ld[i];
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Scoreboard-based hazard interlock, operand forwarding and branch flush for the OF stage.
// Optional HAZARD_STATS_EN adds saturating stall/flush cycle counters.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_IDX_W  = REG_IDX_W_DEF,
    parameter int NUM_STAGES = NUM_STAGES_DEF,
    parameter int LOAD_STAGE = LOAD_STAGE_DEF,
    parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 of_valid,
    input  logic [REG_IDX_W-1:0] of_src1,
    input  logic [REG_IDX_W-1:0] of_src2,
    input  logic                 of_use1,
    input  logic                 of_use2,
    input  logic [REG_IDX_W-1:0] of_rd,
    input  logic                 of_wb,
    input  logic                 of_ld,
    input  logic                 br_taken,
    output logic                 stall,
    output logic                 flush,
    output logic [SEL_W-1:0]     fwd_sel1,
    output logic [SEL_W-1:0]     fwd_sel2
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          flush_cnt
`endif
);

    sb_entry_t sb [NUM_STAGES];
    sb_entry_t entry0_next;

    logic [NUM_STAGES-1:0]               sb_v, sb_wb, sb_ld;
    logic [NUM_STAGES*REG_IDX_W_MAX-1:0] sb_rd;
    logic [REG_IDX_W_MAX-1:0]            src1_x, src2_x;

    logic                                hit1, hit2, hit_ld1, hit_ld2;
    logic [SEL_W-1:0]                    idx1, idx2;
    logic                                ld_stall;

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_flat
        assign sb_v[g]                                   = sb[g].v;
        assign sb_wb[g]                                  = sb[g].wb;
        assign sb_ld[g]                                  = sb[g].ld;
        assign sb_rd[g*REG_IDX_W_MAX +: REG_IDX_W_MAX]   = sb[g].rd;
    end

    assign src1_x = REG_IDX_W_MAX'(of_src1);
    assign src2_x = REG_IDX_W_MAX'(of_src2);

    fwd_match #(.IDX_W(REG_IDX_W_MAX), .NUM_STAGES(NUM_STAGES), .SEL_W(SEL_W)) u_match1 (
        .en(of_valid & of_use1), .src(src1_x), .v(sb_v), .wb(sb_wb), .ld(sb_ld), .rd(sb_rd),
        .hit(hit1), .idx(idx1), .hit_ld(hit_ld1)
    );

    fwd_match #(.IDX_W(REG_IDX_W_MAX), .NUM_STAGES(NUM_STAGES), .SEL_W(SEL_W)) u_match2 (
        .en(of_valid & of_use2), .src(src2_x), .v(sb_v), .wb(sb_wb), .ld(sb_ld), .rd(sb_rd),
        .hit(hit2), .idx(idx2), .hit_ld(hit_ld2)
    );

    // A load result is only usable once the load has reached LOAD_STAGE.
    assign ld_stall = (hit1 && hit_ld1 && (idx1 < SEL_W'(LOAD_STAGE))) ||
                      (hit2 && hit_ld2 && (idx2 < SEL_W'(LOAD_STAGE)));

    assign flush    = br_taken;
    assign stall    = of_valid && !br_taken && ld_stall;
    assign fwd_sel1 = hit1 ? idx1 + SEL_W'(1) : SEL_W'(SEL_RF);
    assign fwd_sel2 = hit2 ? idx2 + SEL_W'(1) : SEL_W'(SEL_RF);

    always_comb begin
        entry0_next = '0;
        if (of_valid && !flush && !stall) begin
            entry0_next.v  = 1'b1;
            entry0_next.rd = REG_IDX_W_MAX'(of_rd);
            entry0_next.wb = of_wb;
            entry0_next.ld = of_ld;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_STAGES; i++) sb[i] <= '0;
        end else begin
            sb[0] <= entry0_next;
            for (int i = 1; i < NUM_STAGES; i++) sb[i] <= sb[i-1];
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
            if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: default (3/2) and deep (5/3) instances against a queue-based model.
module tb_hazard_fwd_ctrl;

    typedef struct packed {
        bit       v;
        bit [3:0] rd;
        bit       wb;
        bit       ld;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       of_valid = 1'b0, of_use1 = 1'b0, of_use2 = 1'b0;
    logic [3:0] of_src1 = '0, of_src2 = '0, of_rd = '0;
    logic       of_wb = 1'b0, of_ld = 1'b0, br_taken = 1'b0;

    logic       stall3, flush3, stall5, flush5;
    logic [1:0] f1_3, f2_3;
    logic [2:0] f1_5, f2_5;
`ifdef HAZARD_STATS_EN
    logic [31:0] scnt3_d, fcnt3_d, scnt5_d, fcnt5_d;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    ent_t q3[$];
    ent_t q5[$];
    bit   e_st3, e_st5;
    int   scnt3, scnt5, fcnt;

    always #5 clk = ~clk;

    hazard_fwd_ctrl u_dut3 (
        .clk(clk), .reset(reset), .of_valid(of_valid),
        .of_src1(of_src1), .of_src2(of_src2), .of_use1(of_use1), .of_use2(of_use2),
        .of_rd(of_rd), .of_wb(of_wb), .of_ld(of_ld), .br_taken(br_taken),
        .stall(stall3), .flush(flush3), .fwd_sel1(f1_3), .fwd_sel2(f2_3)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(scnt3_d), .flush_cnt(fcnt3_d)
`endif
    );

    hazard_fwd_ctrl #(.NUM_STAGES(5), .LOAD_STAGE(3)) u_dut5 (
        .clk(clk), .reset(reset), .of_valid(of_valid),
        .of_src1(of_src1), .of_src2(of_src2), .of_use1(of_use1), .of_use2(of_use2),
        .of_rd(of_rd), .of_wb(of_wb), .of_ld(of_ld), .br_taken(br_taken),
        .stall(stall5), .flush(flush5), .fwd_sel1(f1_5), .fwd_sel2(f2_5)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(scnt5_d), .flush_cnt(fcnt5_d)
`endif
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Youngest in-flight producer of src (queue index 0 = EX); load hazard if it has not reached ls.
    function automatic void predict(input ent_t q[$], input int ls, input bit v, input bit [3:0] s,
                                    input bit u, output int sel, output bit lhaz);
        sel  = 0;
        lhaz = 1'b0;
        if (!(v && u)) return;
        for (int j = 0; j < q.size(); j++) begin
            if (q[j].v && q[j].wb && q[j].rd == s) begin
                sel  = j + 1;
                lhaz = q[j].ld && (j < ls);
                return;
            end
        end
    endfunction

    task automatic clear_model();
        ent_t b;
        b = '0;
        q3 = {};
        q5 = {};
        for (int i = 0; i < 3; i++) q3.push_back(b);
        for (int i = 0; i < 5; i++) q5.push_back(b);
        scnt3 = 0;
        scnt5 = 0;
        fcnt  = 0;
    endtask

    task automatic check_all();
        int s1, s2;
        bit h1, h2;
        predict(q3, 2, of_valid, of_src1, of_use1, s1, h1);
        predict(q3, 2, of_valid, of_src2, of_use2, s2, h2);
        e_st3 = of_valid && !br_taken && (h1 || h2);
        chk("m3_stall", int'(stall3), int'(e_st3));
        chk("m3_sel1", int'(f1_3), s1);
        chk("m3_sel2", int'(f2_3), s2);
        chk("m3_flush", int'(flush3), int'(br_taken));
        predict(q5, 3, of_valid, of_src1, of_use1, s1, h1);
        predict(q5, 3, of_valid, of_src2, of_use2, s2, h2);
        e_st5 = of_valid && !br_taken && (h1 || h2);
        chk("m5_stall", int'(stall5), int'(e_st5));
        chk("m5_sel1", int'(f1_5), s1);
        chk("m5_sel2", int'(f2_5), s2);
        chk("m5_flush", int'(flush5), int'(br_taken));
    endtask

    task automatic apply(input bit v, input bit [3:0] s1, input bit u1, input bit [3:0] s2,
                         input bit u2, input bit [3:0] rd, input bit wb, input bit ld, input bit br);
        of_valid = v;  of_src1 = s1; of_use1 = u1; of_src2 = s2; of_use2 = u2;
        of_rd    = rd; of_wb   = wb; of_ld   = ld; br_taken = br;
        #2;
        check_all();
    endtask

    task automatic tick();
        ent_t e;
        @(posedge clk);
        if (reset) begin
            e = '0;
            if (of_valid && !br_taken && !e_st3) begin
                e.v = 1'b1; e.rd = of_rd; e.wb = of_wb; e.ld = of_ld;
            end
            q3.push_front(e);
            q3.delete(q3.size() - 1);
            e = '0;
            if (of_valid && !br_taken && !e_st5) begin
                e.v = 1'b1; e.rd = of_rd; e.wb = of_wb; e.ld = of_ld;
            end
            q5.push_front(e);
            q5.delete(q5.size() - 1);
            scnt3 += int'(e_st3);
            scnt5 += int'(e_st5);
            fcnt  += int'(br_taken);
        end
        #1;
    endtask

    task automatic reset_pulse();
        of_valid = 1'b0; br_taken = 1'b0;
        reset = 1'b0;
        clear_model();
        #2;
        reset = 1'b1;
    endtask

    task automatic check_counters(input string tag);
`ifdef HAZARD_STATS_EN
        chk({tag, "_scnt3"}, int'(scnt3_d), scnt3);
        chk({tag, "_scnt5"}, int'(scnt5_d), scnt5);
        chk({tag, "_fcnt3"}, int'(fcnt3_d), fcnt);
        chk({tag, "_fcnt5"}, int'(fcnt5_d), fcnt);
`endif
    endtask

    initial begin
        clear_model();
        #6;
        // Reset state: nothing tracked, flush follows br_taken.
        apply(1, 4'd0, 1, 4'd0, 1, 4'd0, 1, 1, 1);
        chk("rst_stall3", int'(stall3), 0);
        chk("rst_sel1_3", int'(f1_3), 0);
        chk("rst_flush3", int'(flush3), 1);
        check_counters("rst");
        tick();
        reset = 1'b1;

        // ALU dependency
        apply(1, 4'd2, 1, 4'd3, 1, 4'd1, 1, 0, 0);
        tick();
        apply(1, 4'd1, 1, 4'd5, 1, 4'd4, 1, 0, 0);
        chk("alu_sel1_3", int'(f1_3), 1);
        chk("alu_stall3", int'(stall3), 0);
        chk("alu_sel1_5", int'(f1_5), 1);
        tick();

        // Load-use
        reset_pulse();
        apply(1, 4'd2, 1, 4'd0, 0, 4'd1, 1, 1, 0);
        tick();
        apply(1, 4'd1, 1, 4'd1, 1, 4'd2, 1, 0, 0);
        chk("lu_c1_stall3", int'(stall3), 1);
        chk("lu_c1_stall5", int'(stall5), 1);
        tick();
        apply(1, 4'd1, 1, 4'd1, 1, 4'd2, 1, 0, 0);
        chk("lu_c2_stall3", int'(stall3), 1);
        tick();
        apply(1, 4'd1, 1, 4'd1, 1, 4'd2, 1, 0, 0);
        chk("lu_c3_stall3", int'(stall3), 0);
        chk("lu_c3_sel1_3", int'(f1_3), 3);
        chk("lu_c3_sel2_3", int'(f2_3), 3);
        chk("lu_c3_stall5", int'(stall5), 1);
        tick();
        apply(1, 4'd1, 1, 4'd1, 1, 4'd2, 1, 0, 0);
        chk("lu_c4_stall5", int'(stall5), 0);
        chk("lu_c4_sel1_5", int'(f1_5), 4);
`ifdef HAZARD_STATS_EN
        chk("lu_stall_cnt3", int'(scnt3_d), 2);
        chk("lu_stall_cnt5", int'(scnt5_d), 3);
`endif
        tick();

        // Youngest producer wins
        reset_pulse();
        apply(1, 4'd0, 0, 4'd0, 0, 4'd1, 1, 0, 0);
        tick();
        apply(1, 4'd0, 0, 4'd0, 0, 4'd1, 1, 0, 0);
        tick();
        apply(1, 4'd1, 1, 4'd0, 0, 4'd2, 1, 0, 0);
        chk("yw_sel1_3", int'(f1_3), 1);
        chk("yw_sel1_5", int'(f1_5), 1);
        tick();

        // Flush beats stall; squashed instruction leaves a bubble
        reset_pulse();
        apply(1, 4'd2, 1, 4'd0, 0, 4'd1, 1, 1, 0);
        tick();
        apply(1, 4'd1, 1, 4'd0, 0, 4'd2, 1, 0, 1);
        chk("fl_flush3", int'(flush3), 1);
        chk("fl_stall3", int'(stall3), 0);
        chk("fl_stall5", int'(stall5), 0);
        tick();
        apply(1, 4'd2, 1, 4'd0, 0, 4'd3, 1, 0, 0);
        chk("fl_bubble3", int'(f1_3), 0);
        chk("fl_bubble5", int'(f1_5), 0);
`ifdef HAZARD_STATS_EN
        chk("fl_flush_cnt3", int'(fcnt3_d), 1);
`endif
        tick();

        // Reset asserted mid-stall
        reset_pulse();
        apply(1, 4'd2, 1, 4'd0, 0, 4'd1, 1, 1, 0);
        tick();
        apply(1, 4'd1, 1, 4'd1, 1, 4'd2, 1, 0, 0);
        chk("rs_pre_stall3", int'(stall3), 1);
        #1;
        reset = 1'b0;
        clear_model();
        #1;
        chk("rs_stall3", int'(stall3), 0);
        chk("rs_stall5", int'(stall5), 0);
        chk("rs_sel1_3", int'(f1_3), 0);
        chk("rs_sel2_5", int'(f2_5), 0);
        tick();
        reset = 1'b1;
        apply(1, 4'd1, 1, 4'd1, 1, 4'd2, 1, 0, 0);
        chk("rs_after_sel1_3", int'(f1_3), 0);
        chk("rs_after_stall3", int'(stall3), 0);
        check_counters("rs");
        tick();

        // Randomized traffic over a small register set
        for (int n = 0; n < 400; n++) begin
            apply($urandom_range(0, 7) != 0, 4'($urandom_range(0, 3)), 1'($urandom),
                  4'($urandom_range(0, 3)), 1'($urandom), 4'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0);
            tick();
        end
        apply(0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0);
        check_counters("end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
